// File: rtl/dm_lane_mem.sv
// Multi-cycle M-stage data memory: byte/half/word loads and stores, sweep-clears itself after reset.
// Accesses stall LATENCY cycles and then pulse done/err; define DM_TRACE_EN to print committed stores.
module dm_lane_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit COMB  = (LATENCY == 0);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_idx_q;
  logic [CW-1:0]         cnt_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  sext_q;
  logic [31:0]           pc_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;

  logic [31:0]           mem_q [DEPTH];

  logic                  a_we;
  logic [1:0]            a_size;
  logic                  a_sext;
  logic [31:0]           a_pc;
  logic [31:0]           a_addr;
  logic [31:0]           a_wdata;
  logic [ADDR_WIDTH-1:0] a_widx;
  logic [1:0]            a_off;
  logic [31:0]           rd_word;
  logic [31:0]           merged;
  logic [31:0]           ld_val;
  logic                  misalign;
  logic                  acc_done;
  logic                  commit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic                  unused_bits;

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] w;
    w = word;
    case (sz)
      2'b00:   w[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   w[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] off, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // With zero latency the live inputs stand in for the request registers.
  assign a_we    = COMB ? we_i       : we_q;
  assign a_size  = COMB ? size_i     : size_q;
  assign a_sext  = COMB ? sign_ext_i : sext_q;
  assign a_pc    = COMB ? pc_i       : pc_q;
  assign a_addr  = COMB ? addr_i     : addr_q;
  assign a_wdata = COMB ? wdata_i    : wdata_q;

  assign a_widx   = a_addr[ADDR_WIDTH+1:2];
  assign a_off    = a_addr[1:0];
  assign rd_word  = mem_q[a_widx];
  assign merged   = lane_merge(rd_word, a_size, a_off, a_wdata);
  assign ld_val   = lane_extract(rd_word, a_size, a_off, a_sext);
  assign misalign = ((a_size == 2'b01) & a_off[0]) | (a_size[1] & (|a_off));

  assign acc_done = COMB ? ((state_q == S_IDLE) && req_i)
                         : ((state_q == S_WAIT) && (cnt_q == '0));
  assign commit   = acc_done & a_we & ~misalign;

  assign done_o  = acc_done;
  assign err_o   = acc_done & misalign;
  assign rdata_o = (acc_done & ~misalign & ~a_we) ? ld_val : 32'h0;
  assign stall_o = (state_q == S_CLEAR)
                 || ((state_q == S_IDLE) && req_i && !COMB)
                 || ((state_q == S_WAIT) && (cnt_q != '0));

  assign unused_bits = ^{a_pc, a_addr[31:ADDR_WIDTH+2]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      pc_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (&clr_idx_q) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (req_i && !COMB) begin
            we_q    <= we_i;
            size_q  <= size_i;
            sext_q  <= sign_ext_i;
            pc_q    <= pc_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= S_IDLE;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // The sweep owns the write port until it finishes; stores only land in the completion cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = a_widx;
    mem_wdata = merged;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = 32'h0;
    end else if (commit) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (commit && !reset_i)
      $display("%d@%h: *%h <= %h", $time, a_pc, {a_addr[31:2], 2'b00}, merged);
  end
`else
`endif

endmodule

// File: tb/tb_dm_lane_mem.sv
// Bench for dm_lane_mem: byte-level reference memory, plan scenarios plus randomized traffic.
module tb_dm_lane_mem;
  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int NB  = 4 << AW;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        sign_ext_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mb [NB];

  dm_lane_mem #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sign_ext_i(sign_ext_i), .pc_i(pc_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sx, input logic [31:0] a);
    int b;
    logic [15:0] h;
    b = int'(a[AW+1:0]);
    case (sz)
      2'b00: return sx ? {{24{mb[b][7]}}, mb[b]} : {24'h0, mb[b]};
      2'b01: begin
        b = b & ~1;
        h = {mb[b+1], mb[b]};
        return sx ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: begin
        b = b & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      end
    endcase
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = int'(a[AW+1:0]);
    case (sz)
      2'b00: mb[b] = wd[7:0];
      2'b01: begin b = b & ~1; mb[b] = wd[7:0]; mb[b+1] = wd[15:8]; end
      default: begin
        b = b & ~3;
        for (int i = 0; i < 4; i++) mb[b+i] = wd[8*i +: 8];
      end
    endcase
  endtask

  // Starts at just after a rising edge; returns just after a rising edge with req dropped.
  task automatic do_access(input string nm, input bit w, input logic [1:0] sz, input bit sx,
                           input logic [31:0] a, input logic [31:0] wd, input bit scramble,
                           output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    bit          mis;
    bit          got;
    int          stalls;
    logic        st_at_done;
    mis    = m_mis(sz, a);
    exp_rd = m_load(sz, sx, a);
    req_i = 1'b1; we_i = w; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
    pc_i = $urandom;
    got = 0; stalls = 0; rd = 32'h0; er = 1'b0; st_at_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        got = 1; rd = rdata_o; er = err_o; st_at_done = stall_o;
        break;
      end
      if (stall_o === 1'b1) stalls++;
      @(posedge clk_i); #1;
      if (scramble && c == 0) begin
        we_i = $urandom; size_i = $urandom; sign_ext_i = $urandom;
        addr_i = $urandom; wdata_i = $urandom;
      end
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: done never seen, required done within 40 cycles", nm);
      return;
    end
    n_checks++;
    if (stalls != LAT) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d required %0d", nm, stalls, LAT);
    end
    n_checks++;
    if (st_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stall_at_done: got %b required 0", nm, st_at_done);
    end
    n_checks++;
    if (er !== mis) begin
      n_fail++;
      $display("FAIL %s err: got %b required %b", nm, er, mis);
    end
    if (mis) begin
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL %s rdata_misaligned: got %h required 00000000", nm, rd);
      end
    end else if (!w) begin
      n_checks++;
      if (rd !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rdata: got %h required %h (addr %h size %0d sx %b)", nm, rd, exp_rd, a, sz, sx);
      end
    end else begin
      m_store(sz, a, wd);
    end
  endtask

  task automatic reset_and_sweep(input string nm);
    int cnt;
    reset_i = 1'b1;
    req_i = 1'b0;
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    #1;
    n_checks++;
    if ({stall_o, done_o, err_o} !== 3'b100 || rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL %s reset_outputs: got stall=%b done=%b err=%b rdata=%h required stall=1 done=0 err=0 rdata=0",
               nm, stall_o, done_o, err_o, rdata_o);
    end
    @(negedge clk_i); @(negedge clk_i);
    n_checks++;
    if (stall_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset_held: got stall=%b done=%b required stall=1 done=0", nm, stall_o, done_o);
    end
    reset_i = 1'b0;
    #1;
    cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      if (stall_o !== 1'b1) break;
      cnt++;
      @(negedge clk_i); #1;
    end
    n_checks++;
    if (cnt != (1 << AW)) begin
      n_fail++;
      $display("FAIL %s sweep_len: got %0d stall cycles required %0d", nm, cnt, 1 << AW);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        er;
    reset_and_sweep("reset");
    for (int i = 0; i < 4; i++) begin
      do_access("reset_load", 1'b0, 2'b10, 1'b0, {$urandom_range(0, 1023), 2'b00}, 32'h0, 1'b0, rd, er);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_load_zero: got %h required 00000000", rd);
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic        er;
    do_access("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 1'b0, rd, er);
    do_access("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'h12345678) begin
      n_fail++; $display("FAIL lw10_const: got %h required 12345678", rd);
    end
  endtask

  task automatic test_bytes();
    logic [31:0] rd;
    logic        er;
    do_access("sb13", 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF80, 1'b0, rd, er);
    do_access("lb13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb13_const: got %h required FFFFFF80", rd); end
    do_access("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu13_const: got %h required 00000080", rd); end
    do_access("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'h80345678) begin n_fail++; $display("FAIL lw10b_const: got %h required 80345678", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd;
    logic        er;
    do_access("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 1'b0, rd, er);
    do_access("lh22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh22_const: got %h required FFFFBEEF", rd); end
    do_access("lhu22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu22_const: got %h required 0000BEEF", rd); end
    do_access("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'hBEEF0000) begin n_fail++; $display("FAIL lw20_const: got %h required BEEF0000", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic        er;
    do_access("sw21", 1'b1, 2'b10, 1'b0, 32'h21, 32'hDEADBEEF, 1'b0, rd, er);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL sw21_err: got %b required 1", er); end
    do_access("lw20m", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'hBEEF0000) begin n_fail++; $display("FAIL lw20m_unchanged: got %h required BEEF0000", rd); end
    do_access("lh23", 1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL lh23_err: got err=%b rdata=%h required err=1 rdata=00000000", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er;
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: got done=%b stall=%b after completion required 0 0", done_o, stall_o);
    end
    @(posedge clk_i); #1;
    do_access("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hCAFEF00D, 1'b0, rd, er);
    do_access("b2b_lw", 1'b0, 2'b10, 1'b0, 32'hFFFF_F030, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_wrap: got %h required CAFEF00D", rd); end
    do_access("wait_scr_sw", 1'b1, 2'b00, 1'b0, 32'h35, 32'h000000A7, 1'b1, rd, er);
    do_access("wait_scr_lb", 1'b0, 2'b00, 1'b1, 32'h35, 32'h0, 1'b1, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFFFA7) begin n_fail++; $display("FAIL wait_ignores_inputs: got %h required FFFFFFA7", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    logic        er;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      a[11:6] = 6'b000100;
      do_access("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, (($urandom & 7) == 0), rd, er);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    logic        er;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; sign_ext_i = 1'b0;
    addr_i = 32'h40; wdata_i = 32'hA5A5A5A5;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL midreset_wait: got stall=%b required 1", stall_o); end
    reset_and_sweep("midreset");
    do_access("midreset_lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, rd, er);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL midreset_lw40: got %h required 00000000", rd); end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    #3;
    test_reset();
    test_word();
    test_bytes();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_lane_mem.md
# dm_lane_mem

Parametrised, multi-cycle data memory for the pipelined MIPS core's M stage. It supports byte, halfword and word stores and loads, with sign or zero extension on loads. A configurable access latency is exposed to the hazard unit through a stall/done handshake. After every reset it clears its own array with a one-word-per-cycle sweep, and it flags misaligned accesses instead of performing them.

## Interface
- ADDR_WIDTH, 10: word-address bits; depth = 2^ADDR_WIDTH words of 32 bits.
- LATENCY, 2: stall cycles per access (0 = single-cycle, combinational read).

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- req  in  1  access request from M stage; held stable while stall=1.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
- pc  in  32  PC of the requesting instruction; used for trace only.
- addr  in  32  byte address; bits above ADDR_WIDTH+1 are ignored (wrap).
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, valid while done=1; 0 otherwise.
- stall  out  1  freeze upstream pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned access; pulses with done.

## Operation
- FSM states: CLEAR, IDLE, WAIT.
- CLEAR
  - Entered on reset.
  - Index counter writes 0 to word idx each cycle, from 0 to 2^ADDR_WIDTH-1, then goes to IDLE.
  - stall=1 throughout; req is ignored.
- IDLE, req=1, LATENCY≥1
  - Capture we/size/sign_ext/pc/addr/wdata into request registers.
  - Load cnt=LATENCY-1 and go to WAIT.
  - stall=1 combinationally in this cycle.
- WAIT
  - stall=1 while cnt≠0; cnt decrements.
  - When cnt=0: stall=0, done=1, rdata driven from the captured request, store committed at the end of this cycle, next state IDLE.
- LATENCY=0
  - No WAIT; in IDLE, done=req, stall=0.
  - rdata is combinational from the live inputs; store commits on the same edge.
- Misalignment
  - Half with addr[0]=1, or word with addr[1:0]≠0.
  - Normal timing, but err=1 with done, no write, rdata=0.
- Store merge
  - Byte: lane addr[1:0] ← wdata[7:0].
  - Half: lanes {addr[1],1},{addr[1],0} ← wdata[15:0].
  - Word: full write.
  - Other lanes unchanged (read-modify-write of the addressed word).
- Load extract
  - Byte: lane addr[1:0].
  - Half: half addr[1].
  - Extended to 32 bits per sign_ext; words are returned unchanged.
- req during WAIT is ignored; the request registers do not change.

## Timing
- Reset values (asynchronous):
  - state=CLEAR, clear index=0, cnt=0.
  - done=0, err=0, rdata=0.
  - stall=1 from reset assertion.
- Clear sweep: 2^ADDR_WIDTH cycles after reset deasserts, then IDLE.
- Access, LATENCY=L≥1
  - Request cycle 0 through cycle L-1: stall=1.
  - Cycle L: stall=0, done=1.
  - Write visible to a load accepted in cycle L+1 or later.
- Back-to-back: a new req presented in cycle L+1 (IDLE) is accepted immediately.
- Reset mid-access: pending store is discarded; the sweep restarts from index 0.
- Reset mid-sweep: the index returns to 0.

## Configuration
- DM_TRACE_EN defined: each committed store prints `"%d@%h: *%h <= %h"` with $time, captured pc, word-aligned byte address, merged 32-bit word.
- DM_TRACE_EN undefined: no display statements are compiled. Behaviour is otherwise identical.

## Test plan
- Reset, then count cycles -> stall=1 for exactly 1024 cycles (ADDR_WIDTH=10). Loading any address afterwards returns 0.
- LATENCY=2: sw addr=0x10 data=0x12345678, then lw 0x10 -> stall 2 cycles per access, done in cycle 2, rdata=0x12345678.
- Byte lanes and extension:
  - sb 0x80 to addr 0x13, then lb 0x13 -> 0xFFFFFF80.
  - lbu 0x13 -> 0x00000080.
  - lw 0x10 -> 0x80345678.
- Halfword:
  - sh 0xBEEF to addr 0x22, then lh 0x22 -> 0xFFFFBEEF.
  - lhu 0x22 -> 0x0000BEEF.
  - lw 0x20 -> 0xBEEF0000.
- Misaligned: sw addr=0x21 -> err=1 with done, and the word at 0x20 is unchanged. lh addr=0x23 -> err=1, rdata=0.
- Reset asserted during WAIT of sw 0x40 data=0xA5A5A5A5 -> all outputs clear immediately. After the sweep, lw 0x40 returns 0, and with DM_TRACE_EN no trace line is printed for the aborted store.
